// File: rtl/axi4_wr_burst_engine_if.sv
`timescale 1ns/1ps
// AXI4 write-channel bundle (AW, W, B) between the burst engine and a memory-side slave.
interface axi4_wr_burst_engine_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0]   M_AXI_AWADDR;
    logic [7:0]          M_AXI_AWLEN;
    logic [2:0]          M_AXI_AWSIZE;
    logic [1:0]          M_AXI_AWBURST;
    logic                M_AXI_AWVALID;
    logic                M_AXI_AWREADY;
    logic [DATA_W-1:0]   M_AXI_WDATA;
    logic [DATA_W/8-1:0] M_AXI_WSTRB;
    logic                M_AXI_WLAST;
    logic                M_AXI_WVALID;
    logic                M_AXI_WREADY;
    logic [1:0]          M_AXI_BRESP;
    logic                M_AXI_BVALID;
    logic                M_AXI_BREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY
    );
endinterface

// File: rtl/axi4_wr_burst_engine.sv
`timescale 1ns/1ps
// Splits a (start address, beat count) write command into AXI4 INCR bursts that never
// cross 4 KB, streams AXIS data onto W, and reports one completion once all B responses return.
module axi4_wr_burst_engine #(
    parameter int C_M_AXI_BURST_LEN  = 16,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 64,
    parameter int P_MAX_OUTSTANDING  = 4
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [15:0]                   i_cmd_beats,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] s_axis_tdata,
    axi4_wr_burst_engine_if.master        m_axi,
    output logic                          o_cpl_valid,
    output logic                          o_cpl_err
);
    localparam int AW   = C_M_AXI_ADDR_WIDTH;
    localparam int BPB  = C_M_AXI_DATA_WIDTH / 8;
    localparam int SIZE = $clog2(BPB);
    localparam int OW   = $clog2(P_MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_AW     = 2'd1,
        S_DATA   = 2'd2,
        S_WAIT_B = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [15:0]     rem_q, rem_d;
    logic [7:0]      beat_q, beat_d;
    logic [AW-1:0]   awaddr_q, awaddr_d;
    logic [7:0]      awlen_q, awlen_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic            err_q, err_d;
    logic            cpl_valid_q, cpl_valid_d;
    logic            cpl_err_q, cpl_err_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            bready_q, bready_d;

    logic            in_data_s;
    logic            awvalid_s;
    logic            wlast_s;
    logic            aw_hs_s;
    logic            w_hs_s;
    logic            b_hs_s;

    // Beats in the next burst: bounded by what is left, the burst cap and the 4 KB page end.
    function automatic logic [16:0] burst_len(input logic [11:0] page_off, input logic [15:0] rem);
        logic [12:0] room_bytes;
        logic [16:0] room_beats;
        logic [16:0] n;
        room_bytes = 13'd4096 - {1'b0, page_off};
        room_beats = 17'(room_bytes >> SIZE);
        n          = {1'b0, rem};
        if (n > 17'(C_M_AXI_BURST_LEN)) begin
            n = 17'(C_M_AXI_BURST_LEN);
        end else begin
            n = n;
        end
        if (n > room_beats) begin
            n = room_beats;
        end else begin
            n = n;
        end
        return n;
    endfunction

    assign in_data_s = (state_q == S_DATA);
    assign awvalid_s = (state_q == S_AW) && (outst_q < OW'(P_MAX_OUTSTANDING));
    assign wlast_s   = in_data_s && (beat_q == awlen_q);
    assign aw_hs_s   = awvalid_s && m_axi.M_AXI_AWREADY;
    assign w_hs_s    = in_data_s && s_axis_tvalid && m_axi.M_AXI_WREADY;
    // A B beat with nothing outstanding is a stray and must not underflow the counter.
    assign b_hs_s    = bready_q && m_axi.M_AXI_BVALID && (outst_q != {OW{1'b0}});

    // Next-state, burst bookkeeping and completion logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        beat_d      = beat_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        outst_d     = outst_q;
        err_d       = err_q;
        cpl_valid_d = 1'b0;
        cpl_err_d   = 1'b0;
        bready_d    = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (i_cmd_valid && cmd_ready_q) begin
                    addr_d  = i_cmd_addr;
                    rem_d   = i_cmd_beats;
                    err_d   = 1'b0;
                    beat_d  = 8'd0;
                    state_d = (i_cmd_beats == 16'd0) ? S_WAIT_B : S_AW;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_AW: begin
                if (aw_hs_s) begin
                    beat_d  = 8'd0;
                    state_d = S_DATA;
                end else begin
                    state_d = S_AW;
                end
            end
            S_DATA: begin
                if (w_hs_s && wlast_s) begin
                    addr_d  = addr_q + ((AW'(awlen_q) + AW'(1)) << SIZE);
                    rem_d   = rem_q - (16'(awlen_q) + 16'd1);
                    beat_d  = 8'd0;
                    state_d = (rem_d != 16'd0) ? S_AW : S_WAIT_B;
                end else if (w_hs_s) begin
                    beat_d = beat_q + 8'd1;
                end else begin
                    beat_d = beat_q;
                end
            end
            S_WAIT_B: begin
                if (outst_q == {OW{1'b0}}) begin
                    cpl_valid_d = 1'b1;
                    cpl_err_d   = err_q;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_WAIT_B;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (b_hs_s && (m_axi.M_AXI_BRESP != 2'b00)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_d;
        end

        case ({aw_hs_s, b_hs_s})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase

        // Address phase values are frozen on entry to AW so they stay stable until AWREADY.
        if ((state_d == S_AW) && (state_q != S_AW)) begin
            awaddr_d = addr_d;
            awlen_d  = 8'(burst_len(addr_d[11:0], rem_d) - 17'd1);
        end else begin
            awaddr_d = awaddr_q;
            awlen_d  = awlen_q;
        end

        cmd_ready_d = (state_d == S_IDLE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= S_IDLE;
            addr_q      <= {AW{1'b0}};
            rem_q       <= 16'd0;
            beat_q      <= 8'd0;
            awaddr_q    <= {AW{1'b0}};
            awlen_q     <= 8'd0;
            outst_q     <= {OW{1'b0}};
            err_q       <= 1'b0;
            cpl_valid_q <= 1'b0;
            cpl_err_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            bready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            beat_q      <= beat_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            outst_q     <= outst_d;
            err_q       <= err_d;
            cpl_valid_q <= cpl_valid_d;
            cpl_err_q   <= cpl_err_d;
            cmd_ready_q <= cmd_ready_d;
            bready_q    <= bready_d;
        end
    end

    assign o_cmd_ready         = cmd_ready_q;
    assign o_cpl_valid         = cpl_valid_q;
    assign o_cpl_err           = cpl_err_q;

    assign m_axi.M_AXI_AWADDR  = awaddr_q;
    assign m_axi.M_AXI_AWLEN   = awlen_q;
    assign m_axi.M_AXI_AWSIZE  = 3'(SIZE);
    assign m_axi.M_AXI_AWBURST = 2'b01;
    assign m_axi.M_AXI_AWVALID = awvalid_s;

    // The W channel is a straight pass-through of the stream while a burst is open.
    assign m_axi.M_AXI_WDATA   = in_data_s ? s_axis_tdata : {C_M_AXI_DATA_WIDTH{1'b0}};
    assign m_axi.M_AXI_WSTRB   = {BPB{1'b1}};
    assign m_axi.M_AXI_WLAST   = wlast_s;
    assign m_axi.M_AXI_WVALID  = in_data_s && s_axis_tvalid;
    assign s_axis_tready       = in_data_s && m_axi.M_AXI_WREADY;

    assign m_axi.M_AXI_BREADY  = bready_q;
endmodule

// File: doc/axi4_wr_burst_engine.md
AXI4_WR_BURST_ENGINE -- requirements
Module: axi4_wr_burst_engine

Interface
REQ-001 SHALL have parameter C_M_AXI_BURST_LEN, default 16: maximum beats per AXI burst (power of 2, 1..256).
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32: AXI address width.
REQ-003 SHALL have parameter C_M_AXI_DATA_WIDTH, default 64: AXI/AXIS data width (64, 128, 256, 512).
REQ-004 SHALL have parameter P_MAX_OUTSTANDING, default 4: maximum AW bursts awaiting B response (1..16).
REQ-005 SHALL have port M_AXI_ACLK  in  1  single clock for all logic.
REQ-006 SHALL have port M_AXI_ARESETN  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port i_cmd_valid  in  1  write command valid.
REQ-008 SHALL have port o_cmd_ready  out  1  command accepted when i_cmd_valid & o_cmd_ready.
REQ-009 SHALL have port i_cmd_addr  in  C_M_AXI_ADDR_WIDTH  start byte address, aligned to DATA_WIDTH/8.
REQ-010 SHALL have port i_cmd_beats  in  16  number of data beats in command.
REQ-011 SHALL have port s_axis_tvalid  in  1  write data valid.
REQ-012 SHALL have port s_axis_tready  out  1  write data ready.
REQ-013 SHALL have port s_axis_tdata  in  C_M_AXI_DATA_WIDTH  write data.
REQ-014 SHALL have port M_AXI_AWADDR  out  C_M_AXI_ADDR_WIDTH  burst address.
REQ-015 SHALL have port M_AXI_AWLEN  out  8  beats-1.
REQ-016 SHALL have port M_AXI_AWSIZE  out  3  log2(DATA_WIDTH/8).
REQ-017 SHALL have port M_AXI_AWBURST  out  2  constant 2'b01 (INCR).
REQ-018 SHALL have port M_AXI_AWVALID  out  1  address valid.
REQ-019 SHALL have port M_AXI_AWREADY  in  1  address ready.
REQ-020 SHALL have port M_AXI_WDATA  out  C_M_AXI_DATA_WIDTH  write data.
REQ-021 SHALL have port M_AXI_WSTRB  out  DATA_WIDTH/8  constant all ones.
REQ-022 SHALL have port M_AXI_WLAST  out  1  last beat of burst.
REQ-023 SHALL have port M_AXI_WVALID  out  1  write data valid.
REQ-024 SHALL have port M_AXI_WREADY  in  1  write data ready.
REQ-025 SHALL have ports M_AXI_BRESP  in  2, M_AXI_BVALID  in  1, M_AXI_BREADY  out  1  write response channel.
REQ-026 SHALL have ports o_cpl_valid  out  1 (one-cycle completion pulse) and o_cpl_err  out  1 (any non-OKAY BRESP in command).

Function
REQ-027 SHALL implement states IDLE, AW, DATA, WAIT_B; o_cmd_ready=1 only in IDLE.
REQ-028 On command accept SHALL latch addr/beats, clear error flag, go AW (beats=0: go WAIT_B, no AW issued).
REQ-029 Burst length n SHALL be min(remaining, C_M_AXI_BURST_LEN, (4096-addr[11:0])/(DATA_WIDTH/8)); no burst crosses a 4 KB boundary.
REQ-030 In AW, AWVALID SHALL assert only when outstanding < P_MAX_OUTSTANDING; AWADDR/AWLEN held stable until AWREADY; handshake -> DATA.
REQ-031 In DATA, WVALID=s_axis_tvalid, s_axis_tready=WREADY, WDATA=s_axis_tdata (combinational); elsewhere both 0.
REQ-032 WLAST SHALL be 1 on beat n of the burst; after its handshake addr += n*DATA_WIDTH/8 (mod 2^ADDR_WIDTH), remaining -= n; remaining>0 -> AW, else WAIT_B.
REQ-033 Outstanding counter SHALL +1 on AW handshake, -1 on B handshake, unchanged if both same cycle; never exceeds P_MAX_OUTSTANDING.
REQ-034 BREADY SHALL be 1 in all states after reset; any BRESP!=2'b00 on B handshake sets the error flag.
REQ-035 In WAIT_B with outstanding=0 (including a B handshake decrementing it to 0 that cycle, counted next cycle), SHALL pulse o_cpl_valid 1 cycle with o_cpl_err, return IDLE.
REQ-036 Stray B handshake with outstanding=0 SHALL be ignored (no underflow).

Reset
REQ-037 While M_AXI_ARESETN=0 at a clock edge: state IDLE, counters/flags 0, AWVALID/WVALID/WLAST/s_axis_tready/o_cpl_valid/o_cpl_err/BREADY/o_cmd_ready=0, AWADDR/AWLEN=0; mid-operation reset abandons the command with no completion.

Verification
REQ-038 Addr 0x0, beats 40, BURST_LEN 16, ready always 1 -> AWLEN 15,15,7 at 0x0,0x80,0x100; one cpl, err 0.
REQ-039 Addr 0xFE0, beats 8, DATA 64 -> bursts AWLEN 3 @0xFE0 and AWLEN 3 @0x1000.
REQ-040 BVALID held 0, beats 160, MAX_OUTSTANDING 4 -> exactly 4 AW handshakes then AWVALID stays 0; release B -> completes 10 bursts.
REQ-041 Beats 32, second BRESP=2'b10 -> o_cpl_err=1 on completion pulse.
REQ-042 Beats 0 -> no AWVALID, cpl pulse err 0; reset asserted mid-DATA -> all outputs 0 next cycle, o_cmd_ready=1 after release.
